prc_reg_arb: RTL and testbench
==============================

Name: prc_reg_arb

Overview:
Two-master arbiter in front of the prc register block's single write/read port. Master 0 is the host CSR bridge and master 1 is the debug/config engine. The block grants one request at a time with round-robin fairness and forwards it as a one-cycle slave strobe. It waits for the slave's ready pulse, then returns ready and read data to the granted master.

Parameters:
TIMEOUT_CYC, 16, slave-ready wait limit in cycles; used only with the optional feature; legal range 2..255.

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
m0_wen / m1_wen  in  1  write request, level
m0_waddr / m1_waddr  in  32  write address
m0_wdata / m1_wdata  in  32  write data
m0_wstrb / m1_wstrb  in  8  write strobes
m0_ren / m1_ren  in  1  read request, level
m0_raddr / m1_raddr  in  32  read address
m0_wrdy / m1_wrdy  out  1  write complete, one-cycle pulse
m0_rrdy / m1_rrdy  out  1  read complete, one-cycle pulse
m0_rdata / m1_rdata  out  32  read data, valid with rrdy
s_wen, s_ren  out  1  slave strobes, one-cycle pulse
s_waddr, s_wdata, s_raddr  out  32  slave address/data
s_wstrb  out  8  slave write strobes
s_wrdy, s_rrdy  in  1  slave completion pulses
s_rdata  in  32  slave read data, valid with s_rrdy
grant  out  1  index of the current or last granted master
busy  out  1  high in every state except IDLE
arb_timeout  out  1  one-cycle error pulse; tied 0 without the optional feature

Behaviour:
- Clock and reset: single clock clk; resetn is asynchronous and active-low. Every output and register resets to 0, the FSM resets to IDLE, and last_grant resets to 1 so that m0 wins the first tie.
- Reset mid-transaction: the transaction is aborted with no ready pulse; masters must re-request after reset.
- Master protocol: a master holds wen/ren, address and data stable until it samples its rdy pulse. It drops the request on the same clock edge on which it samples rdy.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: a master has a request if wen|ren is high.
  - If only one master requests, grant it.
  - If both request, grant the master that is not last_grant.
  - Within the granted master, write beats read when both are high; the read is served on a later grant.
  - On grant, register that master's address/data/strobe onto the s_* outputs, set grant, and go to ISSUE.
- ISSUE: s_wen or s_ren is high for exactly this cycle, then go to WAIT.
- WAIT: on the matching slave ready (s_wrdy for a write, s_rrdy for a read), capture s_rdata for a read and go to DONE. A non-matching slave ready is ignored.
- DONE: the granted master's wrdy or rrdy is high for exactly this cycle, and its rdata holds the captured value. Update last_grant to grant and go to IDLE.
- rdata hold: m*_rdata holds its value until that master's next read completes.
- Latency: with a slave that responds one cycle after its strobe, a request first seen in cycle N produces the slave strobe in N+1 and the master rdy in N+3. The next grant can occur in N+4.
- Slave output hold: s_* address/data/strobe hold their values between grants. Only s_wen and s_ren pulse.

Optional Feature:
Macro PRC_REG_ARB_TIMEOUT_EN.
- With the macro: an 8-bit counter is cleared on entry to WAIT and increments on each WAIT cycle. When it reaches TIMEOUT_CYC with no matching slave ready, the FSM goes to DONE, delivers the master's normal rdy pulse, forces rdata to 32'hDEAD_BEEF for reads, and pulses arb_timeout in the DONE cycle.
- Without the macro: no counter is built, WAIT waits indefinitely, and arb_timeout is constant 0.

Test Plan:
1. m0 reads addr 0x00 with slave rdata 0x1 → s_ren pulses in cycle 1, m0_rrdy pulses in cycle 3 with m0_rdata=0x1, m1 outputs stay 0.
2. m0 and m1 both request writes in the same cycle after reset → m0 is served first, then m1; grant sequence is 0,1, and each wrdy is a single pulse.
3. m1 holds a continuous stream of 3 reads while m0 requests once → grants alternate 1,0,1,1 with no starvation of m0.
4. m0 asserts wen and ren together (waddr 0x04, raddr 0x08) → the write is issued first, the read is issued on the next grant, and s_raddr=0x08.
5. resetn asserted while in WAIT → all outputs are 0 asynchronously, and after release the FSM is in IDLE with no rdy pulse.
6. With PRC_REG_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, the slave never responds → m0_rrdy and arb_timeout pulse 16 cycles after WAIT entry, and m0_rdata=0xDEADBEEF.

Source files
------------

// File: rtl/prc_reg_arb.sv
// -----------------------------------------------------------------------------
// prc_reg_arb
//   Two-master round-robin arbiter in front of the prc register block's single
//   write/read port. Master 0 is the host CSR bridge, master 1 the debug/config
//   engine. One request is granted at a time. It is forwarded to the slave as a
//   one-cycle strobe. The slave's completion pulse is then returned to the
//   granted master as a one-cycle rdy pulse, with read data for reads.
//
//   Optional feature: define PRC_REG_ARB_TIMEOUT_EN to bound the wait for the
//   slave to TIMEOUT_CYC cycles. On expiry the master receives its normal rdy
//   pulse, read data is forced to 32'hDEAD_BEEF, and arb_timeout pulses.
//   Without the macro, WAIT has no bound and arb_timeout is tied low.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   m*_wen/_waddr/_wdata/_wstrb master write request (level) and payload
//   m*_ren/_raddr               master read request (level) and address
//   m*_wrdy, m*_rrdy            per-master completion pulses
//   m*_rdata                    per-master read data, held until next read
//   s_wen, s_ren                one-cycle slave strobes
//   s_waddr/_wdata/_wstrb/_raddr slave payload, held between grants
//   s_wrdy, s_rrdy, s_rdata     slave completion pulses and read data
//   grant                       index of the current or last granted master
//   busy                        high whenever the FSM is not in IDLE
//   arb_timeout                 one-cycle slave timeout pulse
// -----------------------------------------------------------------------------
module prc_reg_arb #(
  parameter int unsigned TIMEOUT_CYC = 16  // legal range 2..255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_wen,
  input  logic [31:0] m0_waddr,
  input  logic [31:0] m0_wdata,
  input  logic [7:0]  m0_wstrb,
  input  logic        m0_ren,
  input  logic [31:0] m0_raddr,
  output logic        m0_wrdy,
  output logic        m0_rrdy,
  output logic [31:0] m0_rdata,
  input  logic        m1_wen,
  input  logic [31:0] m1_waddr,
  input  logic [31:0] m1_wdata,
  input  logic [7:0]  m1_wstrb,
  input  logic        m1_ren,
  input  logic [31:0] m1_raddr,
  output logic        m1_wrdy,
  output logic        m1_rrdy,
  output logic [31:0] m1_rdata,
  output logic        s_wen,
  output logic        s_ren,
  output logic [31:0] s_waddr,
  output logic [31:0] s_wdata,
  output logic [7:0]  s_wstrb,
  output logic [31:0] s_raddr,
  input  logic        s_wrdy,
  input  logic        s_rrdy,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        busy,
  output logic        arb_timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        last_grant;   // master served most recently; the other one wins a tie
  logic        is_write;     // type of the transaction currently granted
  logic        req0, req1;
  logic        sel;          // master chosen in IDLE this cycle
  logic        sel_wen;      // chosen master's write request (write beats read)
  logic        slave_done;   // slave pulse matching the granted transaction type
  logic        timeout_hit;
  logic        to_flag;      // last WAIT exit was caused by the timeout
  logic [31:0] read_val;

  assign req0 = m0_wen | m0_ren;
  assign req1 = m1_wen | m1_ren;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    unique case (state)
      IDLE:    if (req0 || req1) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (slave_done || timeout_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; all outputs are zero in IDLE, which is the reset state.
  always_comb begin
    s_wen       = (state == ISSUE) &&  is_write;
    s_ren       = (state == ISSUE) && !is_write;
    m0_wrdy     = (state == DONE) && !grant &&  is_write;
    m0_rrdy     = (state == DONE) && !grant && !is_write;
    m1_wrdy     = (state == DONE) &&  grant &&  is_write;
    m1_rrdy     = (state == DONE) &&  grant && !is_write;
    busy        = (state != IDLE);
    arb_timeout = (state == DONE) && to_flag;
  end

  // Round-robin choice. With both masters requesting, the one not served last wins.
  always_comb begin
    sel = 1'b0;
    if (req0 && req1) sel = ~last_grant;
    else if (req1)    sel = 1'b1;
  end

  assign sel_wen    = sel ? m1_wen : m0_wen;
  assign slave_done = is_write ? s_wrdy : s_rrdy;

`ifdef PRC_REG_ARB_TIMEOUT_EN
  localparam logic [7:0]  TIMEOUT_LAST  = 8'(TIMEOUT_CYC - 1);
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  logic [7:0] wait_cnt;

  // wait_cnt is 0 in the first WAIT cycle. It reaches TIMEOUT_CYC on the
  // edge that leaves WAIT, so DONE lands TIMEOUT_CYC cycles after WAIT entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 8'd1;
      to_flag  <= timeout_hit && !slave_done;
    end
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == TIMEOUT_LAST);
  assign read_val    = slave_done ? s_rdata : TIMEOUT_RDATA;
`else
  // Keeps the parameter referenced when the timeout logic is compiled out.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^8'(TIMEOUT_CYC);
  assign timeout_hit        = 1'b0;
  assign to_flag            = 1'b0;
  assign read_val           = s_rdata;
`endif

  // Grant, slave payload and per-master read data
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      is_write   <= 1'b0;
      s_waddr    <= '0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
      s_raddr    <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        grant    <= sel;
        is_write <= sel_wen;
        // Only the fields of the granted type are loaded; the rest hold.
        if (sel_wen) begin
          s_waddr <= sel ? m1_waddr : m0_waddr;
          s_wdata <= sel ? m1_wdata : m0_wdata;
          s_wstrb <= sel ? m1_wstrb : m0_wstrb;
        end else begin
          s_raddr <= sel ? m1_raddr : m0_raddr;
        end
      end
      // Read data is written into the master's register while still in WAIT.
      // It is therefore already valid during the DONE rdy pulse.
      if (state == WAIT && !is_write && (slave_done || timeout_hit)) begin
        if (grant) m1_rdata <= read_val;
        else       m0_rdata <= read_val;
      end
      if (state == DONE) last_grant <= grant;
    end
  end

endmodule

// File: tb/tb_prc_reg_arb.sv
// -----------------------------------------------------------------------------
// tb_prc_reg_arb
//   Directed testbench for prc_reg_arb. A background environment process does
//   three jobs:
//     - models the slave, answering one cycle after each strobe with
//       rdata = addr + 1;
//     - drops each master request on the cycle its rdy pulse is seen;
//     - logs slave issues and master completions with cycle stamps.
//   Scenario tasks drive requests and compare the logs against
//   hand-computed values.
// -----------------------------------------------------------------------------
module tb_prc_reg_arb;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        m0_wen = 1'b0, m0_ren = 1'b0, m1_wen = 1'b0, m1_ren = 1'b0;
  logic [31:0] m0_waddr = '0, m0_wdata = '0, m0_raddr = '0;
  logic [31:0] m1_waddr = '0, m1_wdata = '0, m1_raddr = '0;
  logic [7:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_wrdy, m0_rrdy, m1_wrdy, m1_rrdy;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_wen, s_ren;
  logic [31:0] s_waddr, s_wdata, s_raddr;
  logic [7:0]  s_wstrb;
  logic        s_wrdy = 1'b0, s_rrdy = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        grant, busy, arb_timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int to_total = 0;
  bit slave_on = 1'b1;

  typedef struct {
    int          cyc;
    logic        g;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [7:0]  wstrb;
  } issue_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] rdata;
  } rdy_t;

  issue_t iss_q[$];
  rdy_t   rdy0_q[$];
  rdy_t   rdy1_q[$];
  int     to_q[$];

  logic        pend_w = 1'b0, pend_r = 1'b0;
  logic [31:0] pend_addr = '0;

  prc_reg_arb #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .resetn(resetn),
    .m0_wen(m0_wen), .m0_waddr(m0_waddr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ren(m0_ren), .m0_raddr(m0_raddr),
    .m0_wrdy(m0_wrdy), .m0_rrdy(m0_rrdy), .m0_rdata(m0_rdata),
    .m1_wen(m1_wen), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ren(m1_ren), .m1_raddr(m1_raddr),
    .m1_wrdy(m1_wrdy), .m1_rrdy(m1_rrdy), .m1_rdata(m1_rdata),
    .s_wen(s_wen), .s_ren(s_ren),
    .s_waddr(s_waddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_raddr(s_raddr),
    .s_wrdy(s_wrdy), .s_rrdy(s_rrdy), .s_rdata(s_rdata),
    .grant(grant), .busy(busy), .arb_timeout(arb_timeout)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Environment: slave model, master rdy handling, logging (mid-cycle)
  initial forever begin
    @(negedge clk);
    s_wrdy  = pend_w && slave_on;
    s_rrdy  = pend_r && slave_on;
    s_rdata = (pend_r && slave_on) ? pend_addr + 32'd1 : 32'h0;
    pend_w    = s_wen;
    pend_r    = s_ren;
    pend_addr = s_raddr;
    if (s_wen || s_ren)
      iss_q.push_back('{cyc, grant, s_wen, s_waddr, s_wdata, s_raddr, s_wstrb});
    if (m0_wrdy) begin rdy0_q.push_back('{cyc, 1'b1, m0_rdata}); m0_wen = 1'b0; end
    if (m0_rrdy) begin rdy0_q.push_back('{cyc, 1'b0, m0_rdata}); m0_ren = 1'b0; end
    if (m1_wrdy) begin rdy1_q.push_back('{cyc, 1'b1, m1_rdata}); m1_wen = 1'b0; end
    if (m1_rrdy) begin rdy1_q.push_back('{cyc, 1'b0, m1_rdata}); m1_ren = 1'b0; end
    if (arb_timeout) begin to_q.push_back(cyc); to_total++; end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    iss_q.delete();
    rdy0_q.delete();
    rdy1_q.delete();
    to_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetn = 1'b0;
    m0_wen = 1'b0; m0_ren = 1'b0; m1_wen = 1'b0; m1_ren = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    clear_logs();
  endtask

  task automatic wait_counts(input int n_iss, input int n_rdy, input int budget,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (iss_q.size() >= n_iss && (rdy0_q.size() + rdy1_q.size()) >= n_rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({busy, grant, s_wen, s_ren, m0_wrdy, m0_rrdy, m1_wrdy, m1_rrdy, arb_timeout} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000000",
               {busy, grant, s_wen, s_ren, m0_wrdy, m0_rrdy, m1_wrdy, m1_rrdy, arb_timeout});
    end
    checks++;
    if ({m0_rdata, m1_rdata, s_waddr, s_raddr, s_wdata} !== 160'h0) begin
      errors++; $display("FAIL reset_data: data buses not all zero");
    end
    checks++;
    if (s_wstrb !== 8'h00) begin
      errors++; $display("FAIL reset_wstrb: got %h expected 00", s_wstrb);
    end
  endtask

  task automatic test_single_read();
    int t0;
    bit ok;
    apply_reset();
    @(negedge clk);
    t0 = cyc; m0_raddr = 32'h0; m0_ren = 1'b1;
    wait_counts(1, 1, 50, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL rd_timeout: got no completion expected 1"); end
    checks++;
    if (iss_q.size() !== 1 || iss_q[0].cyc !== t0 + 1) begin
      errors++; $display("FAIL rd_strobe_cycle: got n=%0d cyc=%0d expected n=1 cyc=%0d",
                         iss_q.size(), iss_q[0].cyc, t0 + 1);
    end
    checks++;
    if (iss_q[0].wr !== 1'b0 || iss_q[0].g !== 1'b0 || iss_q[0].raddr !== 32'h0) begin
      errors++; $display("FAIL rd_issue: got wr=%b g=%b raddr=%h expected 0 0 0",
                         iss_q[0].wr, iss_q[0].g, iss_q[0].raddr);
    end
    checks++;
    if (rdy0_q.size() !== 1 || rdy0_q[0].cyc !== t0 + 3 || rdy0_q[0].wr !== 1'b0) begin
      errors++; $display("FAIL rd_rrdy_cycle: got n=%0d cyc=%0d expected n=1 cyc=%0d",
                         rdy0_q.size(), rdy0_q[0].cyc, t0 + 3);
    end
    checks++;
    if (rdy0_q[0].rdata !== 32'h1 || m0_rdata !== 32'h1) begin
      errors++; $display("FAIL rd_data: got %h/%h expected 00000001", rdy0_q[0].rdata, m0_rdata);
    end
    checks++;
    if (rdy1_q.size() !== 0 || m1_rdata !== 32'h0) begin
      errors++; $display("FAIL rd_m1_quiet: got n=%0d rdata=%h expected 0 0", rdy1_q.size(), m1_rdata);
    end
  endtask

  task automatic test_both_writes();
    int t0;
    bit ok;
    apply_reset();
    @(negedge clk);
    t0 = cyc;
    m0_waddr = 32'h10; m0_wdata = 32'hA0A0_0001; m0_wstrb = 8'h0F; m0_wen = 1'b1;
    m1_waddr = 32'h20; m1_wdata = 32'hB0B0_0002; m1_wstrb = 8'hF0; m1_wen = 1'b1;
    wait_counts(2, 2, 80, ok);
    repeat (4) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL bw_timeout: got no completion expected 2"); end
    checks++;
    if (iss_q.size() !== 2 || {iss_q[0].g, iss_q[1].g} !== 2'b01) begin
      errors++; $display("FAIL bw_grant_seq: got n=%0d seq=%b%b expected 01",
                         iss_q.size(), iss_q[0].g, iss_q[1].g);
    end
    checks++;
    if (iss_q[0].waddr !== 32'h10 || iss_q[0].wdata !== 32'hA0A0_0001 || iss_q[0].wstrb !== 8'h0F) begin
      errors++; $display("FAIL bw_m0_payload: got %h %h %h expected 10 a0a00001 0f",
                         iss_q[0].waddr, iss_q[0].wdata, iss_q[0].wstrb);
    end
    checks++;
    if (iss_q[1].waddr !== 32'h20 || iss_q[1].wdata !== 32'hB0B0_0002 || iss_q[1].wstrb !== 8'hF0) begin
      errors++; $display("FAIL bw_m1_payload: got %h %h %h expected 20 b0b00002 f0",
                         iss_q[1].waddr, iss_q[1].wdata, iss_q[1].wstrb);
    end
    checks++;
    if (iss_q[1].cyc !== t0 + 5) begin
      errors++; $display("FAIL bw_second_grant: got cyc=%0d expected %0d", iss_q[1].cyc, t0 + 5);
    end
    checks++;
    if (rdy0_q.size() !== 1 || rdy1_q.size() !== 1 || rdy0_q[0].wr !== 1'b1 || rdy1_q[0].wr !== 1'b1) begin
      errors++; $display("FAIL bw_single_pulse: got m0=%0d m1=%0d expected 1 1",
                         rdy0_q.size(), rdy1_q.size());
    end
    checks++;
    if (rdy1_q[0].cyc !== t0 + 7) begin
      errors++; $display("FAIL bw_m1_wrdy: got cyc=%0d expected %0d", rdy1_q[0].cyc, t0 + 7);
    end
  endtask

  task automatic test_fairness();
    bit ok;
    bit stuck = 1'b0;
    bit seen;
    apply_reset();
    @(negedge clk);
    m1_raddr = 32'h100; m1_ren = 1'b1;
    @(negedge clk);
    m0_raddr = 32'h200; m0_ren = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
        @(negedge clk);
        if (!m1_ren) seen = 1'b1;
      end
      if (!seen) stuck = 1'b1;
      @(negedge clk);
      m1_raddr = 32'h100 + 32'(4 * k);
      m1_ren   = 1'b1;
    end
    wait_counts(4, 4, 100, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (stuck || !ok) begin
      errors++; $display("FAIL rr_timeout: got stuck=%b ok=%b expected 0 1", stuck, ok);
    end
    checks++;
    if (iss_q.size() !== 4 || {iss_q[0].g, iss_q[1].g, iss_q[2].g, iss_q[3].g} !== 4'b1011) begin
      errors++; $display("FAIL rr_grant_seq: got n=%0d seq=%b%b%b%b expected 1011", iss_q.size(),
                         iss_q[0].g, iss_q[1].g, iss_q[2].g, iss_q[3].g);
    end
    checks++;
    if (iss_q[0].raddr !== 32'h100 || iss_q[1].raddr !== 32'h200 ||
        iss_q[2].raddr !== 32'h104 || iss_q[3].raddr !== 32'h108) begin
      errors++; $display("FAIL rr_addrs: got %h %h %h %h expected 100 200 104 108",
                         iss_q[0].raddr, iss_q[1].raddr, iss_q[2].raddr, iss_q[3].raddr);
    end
    checks++;
    if (rdy1_q.size() !== 3 || rdy1_q[0].rdata !== 32'h101 ||
        rdy1_q[1].rdata !== 32'h105 || rdy1_q[2].rdata !== 32'h109) begin
      errors++; $display("FAIL rr_m1_data: got n=%0d %h %h %h expected 3 101 105 109",
                         rdy1_q.size(), rdy1_q[0].rdata, rdy1_q[1].rdata, rdy1_q[2].rdata);
    end
    checks++;
    if (rdy0_q.size() !== 1 || m0_rdata !== 32'h201) begin
      errors++; $display("FAIL rr_m0_hold: got n=%0d rdata=%h expected 1 201", rdy0_q.size(), m0_rdata);
    end
  endtask

  task automatic test_write_priority();
    bit ok;
    apply_reset();
    @(negedge clk);
    m0_waddr = 32'h04; m0_wdata = 32'h1234_5678; m0_wstrb = 8'hFF; m0_wen = 1'b1;
    m0_raddr = 32'h08; m0_ren = 1'b1;
    wait_counts(2, 2, 80, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok) begin errors++; $display("FAIL wp_timeout: got no completion expected 2"); end
    checks++;
    if (iss_q.size() !== 2 || iss_q[0].wr !== 1'b1 || iss_q[0].waddr !== 32'h04) begin
      errors++; $display("FAIL wp_write_first: got n=%0d wr=%b waddr=%h expected 2 1 04",
                         iss_q.size(), iss_q[0].wr, iss_q[0].waddr);
    end
    checks++;
    if (iss_q[1].wr !== 1'b0 || iss_q[1].raddr !== 32'h08 || iss_q[1].waddr !== 32'h04 ||
        iss_q[1].g !== 1'b0) begin
      errors++; $display("FAIL wp_read_second: got wr=%b raddr=%h waddr=%h g=%b expected 0 08 04 0",
                         iss_q[1].wr, iss_q[1].raddr, iss_q[1].waddr, iss_q[1].g);
    end
    checks++;
    if (rdy0_q.size() !== 2 || rdy0_q[0].wr !== 1'b1 || rdy0_q[1].wr !== 1'b0 ||
        rdy0_q[1].rdata !== 32'h09) begin
      errors++; $display("FAIL wp_rdy_order: got n=%0d %b%b rdata=%h expected 2 10 09",
                         rdy0_q.size(), rdy0_q[0].wr, rdy0_q[1].wr, rdy0_q[1].rdata);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    slave_on = 1'b0;
    @(negedge clk);
    m1_waddr = 32'h30; m1_wdata = 32'h55; m1_wstrb = 8'h01; m1_wen = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || grant !== 1'b1) begin
      errors++; $display("FAIL rm_in_wait: got busy=%b grant=%b expected 1 1", busy, grant);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy, grant, s_wen, s_ren, m0_wrdy, m0_rrdy, m1_wrdy, m1_rrdy, arb_timeout} !== 9'b0) begin
      errors++; $display("FAIL rm_async_ctrl: got %b expected 000000000",
                         {busy, grant, s_wen, s_ren, m0_wrdy, m0_rrdy, m1_wrdy, m1_rrdy, arb_timeout});
    end
    checks++;
    if ({s_waddr, s_wdata, s_wstrb} !== 72'h0) begin
      errors++; $display("FAIL rm_async_data: got %h %h %h expected 0 0 0", s_waddr, s_wdata, s_wstrb);
    end
    m1_wen = 1'b0;
    clear_logs();
    @(negedge clk);
    resetn = 1'b1;
    slave_on = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || iss_q.size() !== 0 || rdy0_q.size() + rdy1_q.size() !== 0) begin
      errors++; $display("FAIL rm_after_release: got busy=%b iss=%0d rdy=%0d expected 0 0 0",
                         busy, iss_q.size(), rdy0_q.size() + rdy1_q.size());
    end
  endtask

`ifdef PRC_REG_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int t0;
    bit ok;
    apply_reset();
    slave_on = 1'b0;
    @(negedge clk);
    t0 = cyc; m0_raddr = 32'h40; m0_ren = 1'b1;
    wait_counts(1, 1, 100, ok);
    repeat (3) @(negedge clk);
    slave_on = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL to_timeout: got no completion expected 1"); end
    checks++;
    if (rdy0_q.size() !== 1 || rdy0_q[0].cyc !== t0 + 18 || rdy0_q[0].wr !== 1'b0) begin
      errors++; $display("FAIL to_rrdy_cycle: got n=%0d cyc=%0d expected 1 %0d",
                         rdy0_q.size(), rdy0_q[0].cyc, t0 + 18);
    end
    checks++;
    if (rdy0_q[0].rdata !== 32'hDEAD_BEEF || m0_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL to_rdata: got %h/%h expected deadbeef", rdy0_q[0].rdata, m0_rdata);
    end
    checks++;
    if (to_q.size() !== 1 || to_q[0] !== t0 + 18) begin
      errors++; $display("FAIL to_pulse: got n=%0d cyc=%0d expected 1 %0d", to_q.size(), to_q[0], t0 + 18);
    end
  endtask
`else
  task automatic test_timeout();
    apply_reset();
    slave_on = 1'b0;
    @(negedge clk);
    m0_raddr = 32'h40; m0_ren = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rdy0_q.size() !== 0) begin
      errors++; $display("FAIL nto_wait_forever: got busy=%b rdy=%0d expected 1 0", busy, rdy0_q.size());
    end
    apply_reset();
    slave_on = 1'b1;
    checks++;
    if (to_total !== 0) begin
      errors++; $display("FAIL nto_pulse: got %0d arb_timeout pulses expected 0", to_total);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_both_writes();
    test_fairness();
    test_write_priority();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
